// File: rtl/mem20_sched_pkg.sv
// Shared constants for the mem20 serial-output schedulers.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
package me_ser_pkg;

  // Default serial word width; matches the mem20 register.
  localparam int DW_DEFAULT = 20;

  // Counter value of the last shift cycle of a default-width word.
  localparam int SHIFT_LAST = DW_DEFAULT - 2;

  // Sequencer state encoding (kept as plain constants for legacy tools).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  // Increment an index modulo n (used for the round-robin pointer).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem20_sched_if.sv
// Requester bundle for the mem20 scheduler: valid/data in, one-cycle ack out.
// Latency: ack is a registered pulse in the cycle the word is taken.
// Backpressure: a requester holds valid/data until it sees its ack.
interface mem20_sched_if
  import me_ser_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DW_DEFAULT
) ();

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ack;

  // Producers drive valid/data and watch ack.
  modport master (
    output req_valid,
    output req_data,
    input  req_ack
  );

  // The scheduler consumes valid/data and returns ack.
  modport slave (
    input  req_valid,
    input  req_data,
    output req_ack
  );

endinterface

// File: rtl/mem20_sched_rr_arb.sv
// Round-robin arbiter: request vector + start pointer -> one-hot grant and index.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int             j;
  logic [IDW-1:0] jx;
  logic           found;

  assign any_o = |req_i;

  // Scan ptr, ptr+1, ... modulo NREQ and grant the first active request.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    jx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= NREQ) j = j - NREQ;
      jx = IDW'(j);
      if (!found && req_i[jx]) begin
        found     = 1'b1;
        gnt_o[jx] = 1'b1;
        idx_o     = jx;
      end
    end
  end

endmodule

// File: rtl/mem20_sched.sv
// Feeds mem20 one DW-bit word every DW cycles from NREQ requesters; FIXED_PRIO_EN selects fixed priority.
// Latency: ack/en_input/data_raw registered one cycle after arbitration; framing one cycle after LOAD.
// Backpressure: requesters hold valid/data until acked; an un-acked word may be withdrawn.
module mem20_sched
  import me_ser_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DW_DEFAULT,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem20_sched_if.slave        req_if,
  output logic                ser_rst_n,
  output logic                en_input,
  output logic [DW-1:0]       data_raw,
  output logic [IDW-1:0]      grant_id,
  output logic                frame_start,
  output logic                bit_valid,
  output logic                busy
);

  localparam int            CW       = $clog2(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 2);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            en_input_q, en_input_d;
  logic [DW-1:0]   data_raw_q, data_raw_d;
  logic [NREQ-1:0] req_ack_q, req_ack_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic            frame_start_q, bit_valid_q, ser_rst_n_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;
  logic [IDW-1:0]  arb_ptr;
  logic [DW-1:0]   win_data;
  logic            load_now;

`ifdef FIXED_PRIO_EN
  // Fixed priority: always search from requester 0.
  assign arb_ptr = '0;
`else
  logic [IDW-1:0] ptr_q, ptr_d;

  // Next search starts just past the requester that won.
  always_comb begin
    ptr_d = ptr_q;
    if (load_now) ptr_d = IDW'(wrap_inc(int'(arb_idx), NREQ));
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign arb_ptr = ptr_q;
`endif

  rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i (req_if.req_valid),
    .ptr_i (arb_ptr),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Select the winning requester's word from the packed data bus.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) win_data = req_if.req_data[i*DW +: DW];
    end
  end

  // Sequencer: IDLE -> LOAD (1 cycle) -> SHIFT (DW-1 cycles) -> LOAD or IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    en_input_d = 1'b0;
    req_ack_d  = '0;
    data_raw_d = data_raw_q;
    grant_id_d = grant_id_q;
    load_now   = 1'b0;
    case (state_q)
      ST_IDLE: load_now = arb_any;
      ST_LOAD: begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
      end
      ST_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          if (arb_any) load_now = 1'b1;
          else         state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A grant registers the load strobe, word, ack and index together.
    if (load_now) begin
      state_d    = ST_LOAD;
      cnt_d      = '0;
      en_input_d = 1'b1;
      data_raw_d = win_data;
      req_ack_d  = arb_gnt;
      grant_id_d = arb_idx;
    end
  end

  // State, counter and registered mem20/requester outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      en_input_q <= 1'b0;
      data_raw_q <= '0;
      req_ack_q  <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_input_q <= en_input_d;
      data_raw_q <= data_raw_d;
      req_ack_q  <= req_ack_d;
      grant_id_q <= grant_id_d;
    end
  end

  // Framing delayed one cycle from LOAD/SHIFT so it lines up with s_out_port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start_q <= 1'b0;
      bit_valid_q   <= 1'b0;
    end else begin
      frame_start_q <= (state_q == ST_LOAD);
      bit_valid_q   <= (state_q == ST_LOAD) || (state_q == ST_SHIFT);
    end
  end

  // mem20 reset follows rst, released on the first edge after rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ser_rst_n_q <= 1'b0;
    else     ser_rst_n_q <= 1'b1;
  end

  assign req_if.req_ack = req_ack_q;
  assign ser_rst_n      = ser_rst_n_q;
  assign en_input       = en_input_q;
  assign data_raw       = data_raw_q;
  assign grant_id       = grant_id_q;
  assign frame_start    = frame_start_q;
  assign bit_valid      = bit_valid_q;
  assign busy           = (state_q == ST_LOAD) || (state_q == ST_SHIFT);

endmodule

// File: doc/mem20_sched.md
Name: mem20_sched

Overview:
- Scheduler and sequencer for the 20-bit serial output register (mem20) in the full-search block-matching engine.
- Arbitrates up to NREQ result producers (PE-array SAD/motion-vector packers, 20-bit words) with round-robin priority.
- Loads the winning word into mem20 via en_input/data_raw, counts the 19 shift cycles, then loads the next word.
- Emits framing strobes aligned to mem20's s_out_port so downstream logic knows word boundaries.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 20, word width; must equal mem20 width
- IDW, 2, grant index width, clog2(NREQ)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester word available
- req_data  in  NREQ*DW  packed words; requester i at [i*DW +: DW]
- req_ack  out  NREQ  one-cycle pulse: word i taken this cycle
- ser_rst_n  out  1  to mem20 rst_n; registered ~rst
- en_input  out  1  to mem20 en_input; load strobe
- data_raw  out  DW  to mem20 data_raw
- grant_id  out  IDW  index of word currently being serialized
- frame_start  out  1  high in the cycle s_out_port carries bit DW-1 of a word
- bit_valid  out  1  high while s_out_port carries a valid word bit
- busy  out  1  high in LOAD or SHIFT

Behaviour:
- Reset (async, rst=1): state IDLE; en_input=0, data_raw=0, req_ack=0, grant_id=0, frame_start=0, bit_valid=0, busy=0, rr pointer=0, shift counter=0; ser_rst_n=0. ser_rst_n rises on the first posedge after rst deasserts.
- en_input, data_raw, req_ack are registered outputs.
- States:
  - IDLE: if any req_valid, arbitrate and go to LOAD; else stay.
  - LOAD: one cycle; en_input=1, data_raw=req_data of the winner, req_ack[winner]=1, grant_id=winner; cnt=0; go to SHIFT.
  - SHIFT: en_input=0; cnt increments each cycle. At cnt==DW-2 (19 shift cycles total): if any req_valid, arbitrate and go to LOAD; else go to IDLE.
- Back-to-back throughput: one word every DW=20 cycles; no gap cycles.
- Arbitration: round-robin from pointer. Search order is ptr, ptr+1, ... modulo NREQ. After a grant, ptr = winner+1 (wraps NREQ-1 -> 0).
- req_data is sampled in the same cycle the ack is registered. A requester must hold data/valid until acked; valid may drop without ack (no grant occurs).
- Serial alignment, mem20 loads at edge t:
  - s_out_port shows bit DW-1 after edge t+1 and bit 0 after edge t+DW.
  - frame_start is high for exactly the cycle after edge t+1.
  - bit_valid is high from edge t+1 through edge t+DW, continuous across back-to-back words.
  - Derive both with a one-cycle delay of the LOAD/SHIFT state.
- Reset mid-word: outputs return to reset values at once; the partial word is dropped; the requester is not re-acked. mem20 is cleared by ser_rst_n.
- Simultaneous valid on all requesters: each is served exactly once per NREQ words.
- busy=1 in LOAD and SHIFT.

Optional Feature:
- FIXED_PRIO_EN defined: fixed priority; the lowest index wins; the rr pointer is removed.
- Undefined (default): round-robin as above.

Decomposition:
- Shared package me_ser_pkg: state encoding (ST_IDLE, ST_LOAD, ST_SHIFT), DW_DEFAULT=20, SHIFT_LAST=DW-2.
- One sub-module: rr_arb (NREQ request vector plus pointer -> one-hot grant and index). It is purely combinational and reused by other engine schedulers.

Test Plan:
- Single word: req_valid=4'b0001, data 20'hA5A5A -> req_ack[0] one pulse; en_input one cycle; serial 1010_0101_1010_0101_1010 MSB-first; frame_start once; bit_valid high exactly 20 cycles; then IDLE.
- Contention: req_valid=4'b1111 held, all data distinct -> ack order 0,1,2,3,0; loads every 20 cycles; bit_valid never drops.
- Wrap: ptr=3, req_valid=4'b1001 -> grant 3 then 0; grant_id follows.
- Late request: req_valid rises one cycle after the SHIFT last cycle -> IDLE for one cycle, then LOAD; bit_valid shows exactly a 1-cycle gap.
- Reset mid-shift at cnt=7 -> all outputs zero asynchronously; ser_rst_n low; after release, a pending request is re-served from ptr=0.
- FIXED_PRIO_EN build: req_valid=4'b1010 held -> requester 1 acked every word; requester 3 starves.
